// File: rtl/switch_index_decoder_pkg.sv
// Shared types and constants for the switch index decoder board block.
package switch_index_decoder_pkg;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_VALID,
    S_ERROR
  } decoder_state_t;

  // All segments off (active-low display)
  localparam logic [6:0] SEG_BLANK = 7'h7f;

  // Push-button bit positions
  localparam int BTN_UNITS  = 0;
  localparam int BTN_TENS   = 1;
  localparam int BTN_COMMIT = 2;
  localparam int BTN_CLEAR  = 3;

endpackage

// File: rtl/convert_hex_to_seven_segment.sv
// Hex digit to active-low 7-segment pattern (segment order g..a in bits 6..0).
module convert_hex_to_seven_segment (
  input  logic [3:0] hex_value,
  output logic [6:0] converted_value
);

  // Pure lookup, one pattern per hex digit
  always_comb begin
    case (hex_value)
      4'h0:    converted_value = 7'h40;
      4'h1:    converted_value = 7'h79;
      4'h2:    converted_value = 7'h24;
      4'h3:    converted_value = 7'h30;
      4'h4:    converted_value = 7'h19;
      4'h5:    converted_value = 7'h12;
      4'h6:    converted_value = 7'h02;
      4'h7:    converted_value = 7'h78;
      4'h8:    converted_value = 7'h00;
      4'h9:    converted_value = 7'h10;
      4'ha:    converted_value = 7'h08;
      4'hb:    converted_value = 7'h03;
      4'hc:    converted_value = 7'h46;
      4'hd:    converted_value = 7'h21;
      4'he:    converted_value = 7'h06;
      default: converted_value = 7'h0e;
    endcase
  end

endmodule

// File: rtl/pb_edge_detect.sv
// Slow-samples active-low push buttons and emits a one-cycle press pulse per
// released-to-pressed transition seen between two consecutive samples.
module pb_edge_detect #(
  parameter int SAMPLE_DIV = 50000,
  parameter int WIDTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_n,
  output logic [WIDTH-1:0] press_p0
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             sampled;
  logic [WIDTH-1:0] btn_prev;
  logic [WIDTH-1:0] btn_cur;

  assign tick = (cnt == CNT_W'(SAMPLE_DIV - 1));

  // Sample-rate counter and two-deep button history; sampled marks the cycle after a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sampled  <= 1'b0;
      btn_prev <= '1;
      btn_cur  <= '1;
    end else begin
      cnt     <= tick ? '0 : cnt + CNT_W'(1);
      sampled <= tick;
      if (tick) begin
        btn_prev <= btn_cur;
        btn_cur  <= btn_n;
      end
    end
  end

  // Stage p0: press pulse, valid only in the single cycle after a sample
  assign press_p0 = sampled ? (btn_prev & ~btn_cur) : '0;

endmodule

// File: rtl/switch_index_decoder.sv
// Two-digit BCD index entry with commit; drives one red LED at the committed index.
module switch_index_decoder
  import switch_index_decoder_pkg::*;
#(
  parameter int NUM_OUTPUTS = 18,
  parameter int SAMPLE_DIV  = 50000
) (
  input  logic                   CLOCK_50_I,
  input  logic                   RESETN_I,
  input  logic [3:0]             PUSH_BUTTON_N_I,
  output logic [7:0][6:0]        SEVEN_SEGMENT_N_O,
  output logic [NUM_OUTPUTS-1:0] LED_RED_O,
  output logic [8:0]             LED_GREEN_O
);

  localparam logic [NUM_OUTPUTS-1:0] LED_ONE = NUM_OUTPUTS'(1);

  logic [3:0]             press_p0;
  decoder_state_t         state_p1, state_nxt;
  logic [3:0]             units_p1, units_nxt;
  logic [3:0]             tens_p1, tens_nxt;
  logic [3:0]             com_units_p1, com_units_nxt;
  logic [3:0]             com_tens_p1, com_tens_nxt;
  logic [4:0]             index;
  logic [4:0]             com_index_nxt;
  logic [NUM_OUTPUTS-1:0] led_red_p1, led_red_nxt;
  logic [1:0]             led_green_p1, led_green_nxt;
  logic [6:0]             seg_units, seg_tens, seg_com_units, seg_com_tens;

  // Digit increment with wrap back to zero after the top value
  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] top);
    return (d >= top) ? 4'd0 : d + 4'd1;
  endfunction

  // Two BCD digits to binary index
  function automatic logic [4:0] bcd_index(input logic [3:0] tens, input logic [3:0] units);
    return ({1'b0, tens} * 5'd10) + {1'b0, units};
  endfunction

  pb_edge_detect #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .WIDTH     (4)
  ) u_pb_edge_detect (
    .clk     (CLOCK_50_I),
    .rst_n   (RESETN_I),
    .btn_n   (PUSH_BUTTON_N_I),
    .press_p0(press_p0)
  );

  assign index = bcd_index(tens_p1, units_p1);

  // Next-state: clear beats commit, commit beats digit increments
  always_comb begin
    state_nxt     = state_p1;
    units_nxt     = units_p1;
    tens_nxt      = tens_p1;
    com_units_nxt = com_units_p1;
    com_tens_nxt  = com_tens_p1;
    if (press_p0[BTN_CLEAR]) begin
      state_nxt     = S_EMPTY;
      units_nxt     = 4'd0;
      tens_nxt      = 4'd0;
      com_units_nxt = 4'd0;
      com_tens_nxt  = 4'd0;
    end else if (press_p0[BTN_COMMIT]) begin
      if ({27'd0, index} < 32'(NUM_OUTPUTS)) begin
        state_nxt     = S_VALID;
        com_units_nxt = units_p1;
        com_tens_nxt  = tens_p1;
      end else begin
        state_nxt = S_ERROR;
      end
    end else begin
      if (press_p0[BTN_UNITS]) units_nxt = wrap_inc(units_p1, 4'd9);
      if (press_p0[BTN_TENS])  tens_nxt  = wrap_inc(tens_p1, 4'd1);
    end
    com_index_nxt = bcd_index(com_tens_nxt, com_units_nxt);
    led_red_nxt   = (state_nxt == S_VALID) ? (LED_ONE << com_index_nxt) : '0;
    led_green_nxt = {state_nxt == S_ERROR, state_nxt == S_VALID};
  end

  // Stage p1: FSM, digit registers and registered LED drive
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state_p1     <= S_EMPTY;
      units_p1     <= 4'd0;
      tens_p1      <= 4'd0;
      com_units_p1 <= 4'd0;
      com_tens_p1  <= 4'd0;
      led_red_p1   <= '0;
      led_green_p1 <= 2'b00;
    end else begin
      state_p1     <= state_nxt;
      units_p1     <= units_nxt;
      tens_p1      <= tens_nxt;
      com_units_p1 <= com_units_nxt;
      com_tens_p1  <= com_tens_nxt;
      led_red_p1   <= led_red_nxt;
      led_green_p1 <= led_green_nxt;
    end
  end

  convert_hex_to_seven_segment u_seg_units     (.hex_value(units_p1),     .converted_value(seg_units));
  convert_hex_to_seven_segment u_seg_tens      (.hex_value(tens_p1),      .converted_value(seg_tens));
  convert_hex_to_seven_segment u_seg_com_units (.hex_value(com_units_p1), .converted_value(seg_com_units));
  convert_hex_to_seven_segment u_seg_com_tens  (.hex_value(com_tens_p1),  .converted_value(seg_com_tens));

  // Display mux: committed digits are shown only while a valid index is held
  always_comb begin
    SEVEN_SEGMENT_N_O    = {8{SEG_BLANK}};
    SEVEN_SEGMENT_N_O[0] = seg_units;
    SEVEN_SEGMENT_N_O[1] = seg_tens;
    if (state_p1 == S_VALID) begin
      SEVEN_SEGMENT_N_O[2] = seg_com_units;
      SEVEN_SEGMENT_N_O[3] = seg_com_tens;
    end
  end

  assign LED_RED_O   = led_red_p1;
  assign LED_GREEN_O = {7'd0, led_green_p1};

endmodule

// File: tb/tb_switch_index_decoder.sv
// Directed bench for switch_index_decoder with a reference model feeding a scoreboard queue.
module tb_switch_index_decoder;

  localparam int SDIV = 4;
  localparam int NOUT = 18;

  typedef struct {
    logic [NOUT-1:0]  red;
    logic [8:0]       green;
    logic [7:0][6:0]  seg;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      btn_n = 4'hF;
  logic [7:0][6:0] seg;
  logic [NOUT-1:0] led_red;
  logic [8:0]      led_green;

  int   total = 0;
  int   bad = 0;
  int   cyc;
  exp_t sb[$];

  // Reference model state: 0 empty, 1 valid, 2 error
  int m_units, m_tens, m_state, m_cu, m_ct;

  switch_index_decoder #(.NUM_OUTPUTS(NOUT), .SAMPLE_DIV(SDIV)) dut (
    .CLOCK_50_I       (clk),
    .RESETN_I         (rst_n),
    .PUSH_BUTTON_N_I  (btn_n),
    .SEVEN_SEGMENT_N_O(seg),
    .LED_RED_O        (led_red),
    .LED_GREEN_O      (led_green)
  );

  always #5 clk = ~clk;

  // Mirrors the sample counter phase so glitches can be placed between samples
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] hex7(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_units = 0; m_tens = 0; m_state = 0; m_cu = 0; m_ct = 0;
  endtask

  // mask bit set = button pressed in this sample
  task automatic model_apply(input logic [3:0] mask);
    int idx;
    if (mask[3]) begin
      m_state = 0; m_units = 0; m_tens = 0; m_cu = 0; m_ct = 0;
    end else if (mask[2]) begin
      idx = m_tens * 10 + m_units;
      if (idx < NOUT) begin
        m_state = 1; m_cu = m_units; m_ct = m_tens;
      end else begin
        m_state = 2;
      end
    end else begin
      if (mask[0]) m_units = (m_units == 9) ? 0 : m_units + 1;
      if (mask[1]) m_tens  = (m_tens == 1) ? 0 : m_tens + 1;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.red   = (m_state == 1) ? (NOUT'(1) << (m_ct * 10 + m_cu)) : '0;
    e.green = {7'd0, m_state == 2, m_state == 1};
    for (int i = 0; i < 8; i++) e.seg[i] = 7'h7f;
    e.seg[0] = hex7(m_units);
    e.seg[1] = hex7(m_tens);
    if (m_state == 1) begin
      e.seg[2] = hex7(m_cu);
      e.seg[3] = hex7(m_ct);
    end
    sb.push_back(e);
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_red"}, 32'(led_red), 32'(e.red));
    chk({tag, "_green"}, 32'(led_green), 32'(e.green));
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_seg%0d", tag, i), 32'(seg[i]), 32'(e.seg[i]));
  endtask

  task automatic press(input logic [3:0] mask, input string tag);
    model_apply(mask);
    push_exp();
    @(negedge clk);
    btn_n = ~mask;
    repeat (3 * SDIV) @(negedge clk);
    btn_n = 4'hF;
    repeat (3 * SDIV) @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic press_n(input logic [3:0] mask, input int n, input string tag);
    for (int i = 0; i < n; i++) press(mask, tag);
  endtask

  initial begin
    // 1. reset and idle
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    push_exp();
    check_outputs("t1_idle");
    chk("t1_seg0_zero", 32'(seg[0]), 32'h40);
    chk("t1_seg2_blank", 32'(seg[2]), 32'h7f);

    // 2. dial 17 and commit
    press_n(4'b0001, 7, "t2_units");
    press(4'b0010, "t2_tens");
    press(4'b0100, "t2_commit");
    chk("t2_led17", 32'(led_red), 32'h20000);
    chk("t2_seg_units7", 32'(seg[2]), 32'h78);
    chk("t2_seg_tens1", 32'(seg[3]), 32'h79);

    // 3. index 18 -> error, then wrap units to 17 -> valid
    press(4'b1000, "t3_clear");
    press_n(4'b0001, 8, "t3_units");
    press(4'b0010, "t3_tens");
    press(4'b0100, "t3_commit18");
    chk("t3_err_green", 32'(led_green), 32'h2);
    chk("t3_err_red", 32'(led_red), 32'h0);
    press_n(4'b0001, 9, "t3_units_wrap");
    press(4'b0100, "t3_commit17");
    chk("t3_led17", 32'(led_red), 32'h20000);

    // 4. long hold fires once; short glitch between samples does nothing
    model_apply(4'b0001);
    push_exp();
    @(negedge clk);
    btn_n = 4'b1110;
    repeat (20 * SDIV) @(negedge clk);
    btn_n = 4'hF;
    repeat (3 * SDIV) @(negedge clk);
    check_outputs("t4_hold");
    push_exp();
    for (int i = 0; i < 2 * SDIV && (cyc % SDIV) != 0; i++) @(negedge clk);
    btn_n = 4'b1110;
    @(negedge clk);
    btn_n = 4'hF;
    repeat (3 * SDIV) @(negedge clk);
    check_outputs("t4_glitch");

    // index 19 is also out of range; then 10 is committed twice
    press(4'b0001, "t4_units19");
    press(4'b0100, "t4_commit19");
    press(4'b0001, "t4_units10");
    press(4'b0100, "t4_commit10");
    press(4'b0100, "t4_recommit10");
    chk("t4_led10", 32'(led_red), 32'h400);

    // 5. commit and clear in the same sample
    press(4'b1100, "t5_commit_clear");
    chk("t5_red", 32'(led_red), 32'h0);
    chk("t5_seg_units", 32'(seg[0]), 32'h40);
    chk("t5_seg_tens", 32'(seg[1]), 32'h40);

    // 6. async reset while editing pending 13 with valid index 5
    press_n(4'b0001, 5, "t6_units");
    press(4'b0100, "t6_commit5");
    press_n(4'b0001, 8, "t6_units_wrap");
    press(4'b0010, "t6_tens");
    chk("t6_led5", 32'(led_red), 32'h20);
    chk("t6_pend_units3", 32'(seg[0]), 32'h30);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    push_exp();
    check_outputs("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * SDIV) @(negedge clk);
    push_exp();
    check_outputs("t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog keeps the run bounded
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
